wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fsm.sv | 67 ++++++
 rtl/wb_stage.sv | 87 ++++++++
 tb/tb_wb_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: datapath width, register
// address width and the FSM state encoding.
package wb_pkg;

  localparam int INSTR_WIDTH    = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int RETIRED_WIDTH  = 32;

  // EMPTY: nothing held. READY: result held, written this cycle.
  // WAIT_MEM: load captured, waiting for the data-memory response.
  typedef enum logic [1:0] {
    WB_EMPTY    = 2'b00,
    WB_READY    = 2'b01,
    WB_WAIT_MEM = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_fsm.sv
// Writeback control FSM. Owns the state register and the registered stall,
// and produces the per-edge strobes the datapath uses:
//   capture   - MEM stage fields are sampled at this edge (valid instruction)
//   load_done - load data is latched at this edge
//   retire    - the held instruction leaves READY at this edge
// Handshake: the MEM stage may only advance an instruction into this stage on
// an edge where stall is 0; while stall is 1 the MEM inputs are ignored and
// the upstream must hold them. rvalid is only consumed in WAIT_MEM.
module wb_fsm
  import wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      mem_valid,
  input  logic      mem_wb_sel,
  input  logic      dmem_rvalid,
  input  logic      flush,
  output wb_state_e state,
  output logic      stall,
  output logic      capture,
  output logic      load_done,
  output logic      retire
);

  wb_state_e state_next;

  // Next-state and strobe decode; flush dominates capture and rvalid.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load_done  = 1'b0;
    retire     = (state == WB_READY);
    if (flush) begin
      state_next = WB_EMPTY;
    end else begin
      case (state)
        WB_EMPTY, WB_READY: begin
          if (mem_valid) begin
            capture    = 1'b1;
            state_next = mem_wb_sel ? WB_WAIT_MEM : WB_READY;
          end else begin
            state_next = WB_EMPTY;
          end
        end
        WB_WAIT_MEM: begin
          if (dmem_rvalid) begin
            load_done  = 1'b1;
            state_next = WB_READY;
          end
        end
        default: state_next = WB_EMPTY;
      endcase
    end
  end

  // State register plus registered stall, which mirrors WAIT_MEM exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WB_EMPTY;
      stall <= 1'b0;
    end else begin
      state <= state_next;
      stall <= (state_next == WB_WAIT_MEM);
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction from MEM, waits for load data when
// needed, and presents a single-cycle register-file write in READY. Also
// counts retired instructions (every exit from READY, including r0 writes
// and non-writing instructions).
module wb_stage
  import wb_pkg::*;
#(
  parameter int INSTR_WIDTH = wb_pkg::INSTR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      W_MEM_valid,
  input  logic                      W_MEM_w_reg_ena,
  input  logic [REG_ADDR_WIDTH-1:0] W_MEM_w_addr,
  input  logic [INSTR_WIDTH-1:0]    W_MEM_alu_res,
  input  logic                      W_MEM_wb_sel,
  input  logic                      W_dmem_rvalid,
  input  logic [INSTR_WIDTH-1:0]    W_dmem_rdata,
  input  logic                      W_flush,
  output logic                      W_WB_w_reg_ena,
  output logic [REG_ADDR_WIDTH-1:0] W_WB_w_addr,
  output logic [INSTR_WIDTH-1:0]    W_WB_w_data,
  output logic                      W_WB_stall,
  output logic [RETIRED_WIDTH-1:0]  W_WB_retired
);

  wb_state_e                 state;
  logic                      capture;
  logic                      load_done;
  logic                      retire;
  logic                      ena_q;
  logic [REG_ADDR_WIDTH-1:0] addr_q;
  logic [INSTR_WIDTH-1:0]    data_q;
  logic [RETIRED_WIDTH-1:0]  retired_q;

  wb_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (W_MEM_valid),
    .mem_wb_sel  (W_MEM_wb_sel),
    .dmem_rvalid (W_dmem_rvalid),
    .flush       (W_flush),
    .state       (state),
    .stall       (W_WB_stall),
    .capture     (capture),
    .load_done   (load_done),
    .retire      (retire)
  );

  // Held instruction fields; a load keeps the old data until its response
  // arrives so w_data stays stable while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (capture) begin
        ena_q  <= W_MEM_w_reg_ena;
        addr_q <= W_MEM_w_addr;
        if (!W_MEM_wb_sel) begin
          data_q <= W_MEM_alu_res;
        end
      end else if (load_done) begin
        data_q <= W_dmem_rdata;
      end
    end
  end

  // Retired-instruction counter; wraps naturally at its full width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  // Write port: r0 is never written even if the instruction asks for it.
  always_comb begin
    W_WB_w_reg_ena = (state == WB_READY) && ena_q && (addr_q != '0);
    W_WB_w_addr    = addr_q;
    W_WB_w_data    = data_q;
    W_WB_retired   = retired_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a directed vector table, a reset-during-load sequence,
// and randomized traffic checked against a transaction-level model.
module tb_wb_stage;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         mem_valid;
  logic         mem_ena;
  logic [4:0]   mem_addr;
  logic [W-1:0] mem_alu;
  logic         mem_sel;
  logic         rvalid;
  logic [W-1:0] rdata;
  logic         flush;
  logic         wb_ena;
  logic [4:0]   wb_addr;
  logic [W-1:0] wb_data;
  logic         wb_stall;
  logic [31:0]  wb_retired;

  int checks = 0;
  int errors = 0;

  wb_stage #(.INSTR_WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .W_MEM_valid     (mem_valid),
    .W_MEM_w_reg_ena (mem_ena),
    .W_MEM_w_addr    (mem_addr),
    .W_MEM_alu_res   (mem_alu),
    .W_MEM_wb_sel    (mem_sel),
    .W_dmem_rvalid   (rvalid),
    .W_dmem_rdata    (rdata),
    .W_flush         (flush),
    .W_WB_w_reg_ena  (wb_ena),
    .W_WB_w_addr     (wb_addr),
    .W_WB_w_data     (wb_data),
    .W_WB_stall      (wb_stall),
    .W_WB_retired    (wb_retired)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // One slot: nothing held, a load waiting for data, or a finished result.
  typedef enum int {M_NONE, M_LOAD, M_DONE} slot_e;
  slot_e        m_slot;
  logic         m_ena;
  logic [4:0]   m_addr;
  logic [W-1:0] m_data;
  logic [31:0]  m_retired;
  logic [W+4:0] exp_q[$];   // expected writes {addr, data}

  task automatic model_reset();
    m_slot    = M_NONE;
    m_ena     = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    m_retired = '0;
    exp_q.delete();
  endtask

  // Apply the stage's rules for one clock edge, using the inputs just driven.
  task automatic model_edge();
    if (m_slot == M_DONE) m_retired = m_retired + 1;
    if (flush) begin
      m_slot = M_NONE;
    end else if (m_slot == M_LOAD) begin
      if (rvalid) begin
        m_data = rdata;
        m_slot = M_DONE;
      end
    end else if (mem_valid) begin
      m_ena  = mem_ena;
      m_addr = mem_addr;
      if (mem_sel) begin
        m_slot = M_LOAD;
      end else begin
        m_data = mem_alu;
        m_slot = M_DONE;
      end
    end else begin
      m_slot = M_NONE;
    end
    if (m_slot == M_DONE && m_ena && m_addr != 0) exp_q.push_back({m_addr, m_data});
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare DUT outputs with the model (called away from the clock edge).
  task automatic model_compare();
    logic [W+4:0] w;
    check("model_stall", {31'b0, wb_stall}, {31'b0, (m_slot == M_LOAD)});
    check("model_retired", wb_retired, m_retired);
    check("model_write_present", {31'b0, wb_ena}, {31'b0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      if (wb_ena) begin
        check("model_w_addr", {27'b0, wb_addr}, {27'b0, w[W+4:W]});
        check("model_w_data", wb_data, w[W-1:0]);
      end
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [4:0] a, input logic [W-1:0] alu,
                       input logic s, input logic r, input logic [W-1:0] rd, input logic f);
    mem_valid = v; mem_ena = e; mem_addr = a; mem_alu = alu;
    mem_sel = s; rvalid = r; rdata = rd; flush = f;
  endtask

  // One cycle: inputs driven at the falling edge, model advanced at the
  // rising edge, outputs checked at the next falling edge.
  task automatic step(input logic v, input logic e, input logic [4:0] a, input logic [W-1:0] alu,
                      input logic s, input logic r, input logic [W-1:0] rd, input logic f);
    drive(v, e, a, alu, s, r, rd, f);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_compare();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic v, e; logic [4:0] a; logic [W-1:0] alu; logic s, r; logic [W-1:0] rd; logic f;
    logic x_ena; logic chk_ad; logic [4:0] x_addr; logic [W-1:0] x_data; logic x_stall; logic [31:0] x_ret;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic v, input logic e, input logic [4:0] a, input logic [W-1:0] alu,
                              input logic s, input logic r, input logic [W-1:0] rd, input logic f,
                              input logic x_ena, input logic chk_ad, input logic [4:0] x_addr,
                              input logic [W-1:0] x_data, input logic x_stall, input logic [31:0] x_ret);
    vec_t t;
    t.v = v; t.e = e; t.a = a; t.alu = alu; t.s = s; t.r = r; t.rd = rd; t.f = f;
    t.x_ena = x_ena; t.chk_ad = chk_ad; t.x_addr = x_addr; t.x_data = x_data;
    t.x_stall = x_stall; t.x_ret = x_ret;
    return t;
  endfunction

  initial begin
    // ALU write to r5, then idle
    tbl[0]  = mk(1, 1, 5, 32'h0000_1234, 0, 0, 0, 0,             1, 1, 5, 32'h1234, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 1);
    // load to r8; an ALU op offered while stalled must be ignored
    tbl[2]  = mk(1, 1, 8, 0, 1, 0, 0, 0,                          0, 0, 0, 0, 1, 1);
    tbl[3]  = mk(1, 1, 3, 32'h77, 0, 0, 0, 0,                     0, 0, 0, 0, 1, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 1, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0,              1, 1, 8, 32'hDEAD_BEEF, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 2);
    // write to r0 is suppressed but still retires
    tbl[7]  = mk(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0,              0, 1, 0, 32'hFFFF_FFFF, 0, 2);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 3);
    // flush in WAIT_MEM with a coincident response
    tbl[9]  = mk(1, 1, 9, 0, 1, 0, 0, 0,                          0, 0, 0, 0, 1, 3);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 32'h1, 1,                      0, 0, 0, 0, 0, 3);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 3);
    // four back-to-back ALU writes to r1..r4
    tbl[12] = mk(1, 1, 1, 32'h11, 0, 0, 0, 0,                     1, 1, 1, 32'h11, 0, 3);
    tbl[13] = mk(1, 1, 2, 32'h22, 0, 0, 0, 0,                     1, 1, 2, 32'h22, 0, 4);
    tbl[14] = mk(1, 1, 3, 32'h33, 0, 0, 0, 0,                     1, 1, 3, 32'h33, 0, 5);
    tbl[15] = mk(1, 1, 4, 32'h44, 0, 0, 0, 0,                     1, 1, 4, 32'h44, 0, 6);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 7);
    // rvalid outside WAIT_MEM is ignored
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 32'h5555, 0,                   0, 0, 0, 0, 0, 7);
    // instruction with w_reg_ena = 0 still retires
    tbl[18] = mk(1, 0, 7, 32'hABC, 0, 0, 0, 0,                    0, 1, 7, 32'hABC, 0, 7);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 8);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ena", {31'b0, wb_ena}, 0);
    check("reset_addr", {27'b0, wb_addr}, 0);
    check("reset_data", wb_data, 0);
    check("reset_stall", {31'b0, wb_stall}, 0);
    check("reset_retired", wb_retired, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].v, tbl[i].e, tbl[i].a, tbl[i].alu, tbl[i].s, tbl[i].r, tbl[i].rd, tbl[i].f);
      check($sformatf("vec%0d_ena", i), {31'b0, wb_ena}, {31'b0, tbl[i].x_ena});
      check($sformatf("vec%0d_stall", i), {31'b0, wb_stall}, {31'b0, tbl[i].x_stall});
      check($sformatf("vec%0d_retired", i), wb_retired, tbl[i].x_ret);
      if (tbl[i].chk_ad) begin
        check($sformatf("vec%0d_addr", i), {27'b0, wb_addr}, {27'b0, tbl[i].x_addr});
        check($sformatf("vec%0d_data", i), wb_data, tbl[i].x_data);
      end
    end

    // Reset in the middle of a pending load, then a late response.
    step(1, 1, 12, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("midload_stall", {31'b0, wb_stall}, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_ena", {31'b0, wb_ena}, 0);
    check("midrst_addr", {27'b0, wb_addr}, 0);
    check("midrst_data", wb_data, 0);
    check("midrst_stall", {31'b0, wb_stall}, 0);
    check("midrst_retired", wb_retired, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD, 0);
    check("late_rvalid_ena", {31'b0, wb_ena}, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("late_rvalid_retired", wb_retired, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 8,
           5'($urandom_range(0, 7)),
           $urandom,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) < 3,
           $urandom,
           $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
